// File: rtl/frac_sad_select.sv
// frac_sad_select: accumulates per-candidate SAD over HEIGHT rows for NUM_CAND
// candidates of a fractional motion search and tracks the lowest-SAD candidate.
// Ports: clk/reset (sync, active-high); start pulse; row_valid + pred_row/orig_row
//   row input; busy; cand_valid/cand_sad/cand_idx per-candidate result (1 cycle
//   after the candidate's last row); done/best_idx/best_sad final search result.
module frac_sad_select #(
  parameter int HEIGHT   = 8,
  parameter int WIDTH    = 8,
  parameter int NUM_CAND = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 row_valid,
  input  logic [WIDTH*8-1:0]   pred_row,
  input  logic [WIDTH*8-1:0]   orig_row,
  output logic                 busy,
  output logic                 cand_valid,
  output logic [13:0]          cand_sad,
  output logic [3:0]           cand_idx,
  output logic                 done,
  output logic [3:0]           best_idx,
  output logic [13:0]          best_sad
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t        state;
  logic [RW-1:0] row_cnt;
  logic [3:0]    cand_cnt;
  logic [13:0]   acc;

  logic [7:0]    pix_p;
  logic [7:0]    pix_o;
  logic [10:0]   row_sad;
  logic [13:0]   cand_total;
  logic          accept;
  logic          last_row;
  logic          last_cand;

  // Sum of absolute pixel differences for the row presented this cycle.
  always_comb begin
    pix_p   = '0;
    pix_o   = '0;
    row_sad = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pix_p   = pred_row[8*i +: 8];
      pix_o   = orig_row[8*i +: 8];
      row_sad = row_sad + 11'((pix_p > pix_o) ? (pix_p - pix_o) : (pix_o - pix_p));
    end
  end

  // Running total including the current row; on the last row this is the
  // finished candidate SAD, so the result can be registered without a bubble.
  assign cand_total = acc + 14'(row_sad);
  // A start in ACCUM restarts the search, so its row is dropped as well.
  assign accept     = (state == ACCUM) && row_valid && !start;
  assign last_row   = (row_cnt == RW'(HEIGHT - 1));
  assign last_cand  = (cand_cnt == 4'(NUM_CAND - 1));
  assign busy       = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row_cnt    <= '0;
      cand_cnt   <= '0;
      acc        <= '0;
      cand_valid <= 1'b0;
      cand_sad   <= '0;
      cand_idx   <= '0;
      done       <= 1'b0;
      best_idx   <= '0;
      best_sad   <= '0;
    end else begin
      cand_valid <= 1'b0;
      done       <= 1'b0;
      if (start) begin
        // Fresh search, or abort of a running one: partial sums are discarded.
        state    <= ACCUM;
        row_cnt  <= '0;
        cand_cnt <= '0;
        acc      <= '0;
        best_idx <= '0;
        best_sad <= '0;
      end else if (accept) begin
        if (last_row) begin
          row_cnt    <= '0;
          acc        <= '0;
          cand_valid <= 1'b1;
          cand_sad   <= cand_total;
          cand_idx   <= cand_cnt;
          // Strict less-than keeps the lower index on ties.
          if (cand_cnt == 4'd0 || cand_total < best_sad) begin
            best_idx <= cand_cnt;
            best_sad <= cand_total;
          end
          if (last_cand) begin
            done     <= 1'b1;
            state    <= IDLE;
            cand_cnt <= '0;
          end else begin
            cand_cnt <= cand_cnt + 4'd1;
          end
        end else begin
          row_cnt <= row_cnt + RW'(1);
          acc     <= cand_total;
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_sad_select.sv
// tb_frac_sad_select: directed stimulus for frac_sad_select with a per-cycle
// comparison against a search-level reference model, plus literal expectations
// for candidate SAD lists, best selection, latency, abort and reset behaviour.
module tb_frac_sad_select;

  localparam int H  = 8;
  localparam int W  = 8;
  localparam int NC = 9;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        row_valid;
  logic [63:0] pred_row;
  logic [63:0] orig_row;
  logic        busy;
  logic        cand_valid;
  logic [13:0] cand_sad;
  logic [3:0]  cand_idx;
  logic        done;
  logic [3:0]  best_idx;
  logic [13:0] best_sad;

  frac_sad_select #(.HEIGHT(H), .WIDTH(W), .NUM_CAND(NC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .row_valid  (row_valid),
    .pred_row   (pred_row),
    .orig_row   (orig_row),
    .busy       (busy),
    .cand_valid (cand_valid),
    .cand_sad   (cand_sad),
    .cand_idx   (cand_idx),
    .done       (done),
    .best_idx   (best_idx),
    .best_sad   (best_sad)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the search as a list of accepted rows and per-candidate totals;
  // the best candidate is recomputed as an argmin over finished candidates.
  bit m_active;
  int m_rows;
  int m_c;
  int m_sum [NC];
  bit m_cv;
  bit m_done;
  int m_csad;
  int m_cidx;
  int m_bidx;
  int m_bsad;

  function automatic int ref_row_sad(input logic [63:0] p, input logic [63:0] o);
    int s;
    int a;
    int b;
    s = 0;
    for (int i = 0; i < W; i++) begin
      a = int'(p[8*i +: 8]);
      b = int'(o[8*i +: 8]);
      s += (a > b) ? (a - b) : (b - a);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    m_cv   = 1'b0;
    m_done = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_rows   = 0;
      m_csad   = 0;
      m_cidx   = 0;
      m_bidx   = 0;
      m_bsad   = 0;
    end else if (start) begin
      m_active = 1'b1;
      m_rows   = 0;
      foreach (m_sum[j]) m_sum[j] = 0;
      m_bidx   = 0;
      m_bsad   = 0;
    end else if (m_active && row_valid) begin
      m_c = m_rows / H;
      m_sum[m_c] += ref_row_sad(pred_row, orig_row);
      m_rows++;
      if (m_rows % H == 0) begin
        m_cv   = 1'b1;
        m_csad = m_sum[m_c];
        m_cidx = m_c;
        m_bidx = 0;
        for (int j = 1; j <= m_c; j++)
          if (m_sum[j] < m_sum[m_bidx]) m_bidx = j;
        m_bsad = m_sum[m_bidx];
        if (m_c == NC - 1) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int  seen [$];
  int  done_cnt;
  int  done_time;

  initial begin
    done_cnt  = 0;
    done_time = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy",       32'(busy),       32'(m_active));
      chk("cand_valid", 32'(cand_valid), 32'(m_cv));
      chk("cand_sad",   32'(cand_sad),   m_csad);
      chk("cand_idx",   32'(cand_idx),   m_cidx);
      chk("done",       32'(done),       32'(m_done));
      chk("best_idx",   32'(best_idx),   m_bidx);
      chk("best_sad",   32'(best_sad),   m_bsad);
      if (cand_valid === 1'b1) seen.push_back(int'(cand_sad));
      if (done === 1'b1) begin
        done_cnt++;
        done_time = int'($time);
      end
    end
  end

  // ---------------- stimulus ----------------
  int last_row_time;

  task automatic drive(input bit r, input bit st, input bit rv,
                       input logic [63:0] p, input logic [63:0] o);
    @(negedge clk);
    reset     = r;
    start     = st;
    row_valid = rv;
    pred_row  = p;
    orig_row  = o;
  endtask

  // mode 0: pred = orig + off per pixel; mode 1: |diff| = 1; mode 2: 0xFF vs 0.
  task automatic mk(input int mode, input int off, output logic [63:0] p, output logic [63:0] o);
    int ov;
    int pv;
    p = '0;
    o = '0;
    for (int i = 0; i < W; i++) begin
      if (mode == 0) begin
        ov = int'($urandom_range(0, 247));
        pv = ov + off;
      end else if (mode == 1) begin
        ov = int'($urandom_range(1, 200));
        pv = (i % 2 == 1) ? ov + 1 : ov - 1;
      end else begin
        ov = 0;
        pv = 255;
      end
      o[8*i +: 8] = ov[7:0];
      p[8*i +: 8] = pv[7:0];
    end
  endtask

  function automatic int cand_off(input int k, input int off0);
    if (k == 5) return 0;
    if (k == 0) return off0;
    return k;
  endfunction

  task automatic send_rows(input int mode, input int off0, input bit gaps, input int nrows);
    logic [63:0] p;
    logic [63:0] o;
    for (int n = 0; n < nrows; n++) begin
      mk(mode, cand_off(n / H, off0), p, o);
      drive(1'b0, 1'b0, 1'b1, p, o);
      last_row_time = int'($time);
      if (gaps) drive(1'b0, 1'b0, 1'b0, p, o);
    end
  endtask

  task automatic run_search(input int mode, input int off0, input bit gaps, input bit junk);
    logic [63:0] p;
    logic [63:0] o;
    seen.delete();
    done_cnt = 0;
    if (junk) begin
      mk(0, 7, p, o);
      drive(1'b0, 1'b0, 1'b1, p, o);   // row while idle
      mk(0, 7, p, o);
      drive(1'b0, 1'b1, 1'b1, p, o);   // row on the start cycle
    end else begin
      drive(1'b0, 1'b1, 1'b0, '0, '0);
    end
    send_rows(mode, off0, gaps, NC * H);
    for (int n = 0; n < 4; n++) drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_results(input string tag, input int exp_sad [NC],
                               input int exp_bidx, input int exp_bsad);
    chk({tag, "_num_cand"}, seen.size(), NC);
    for (int k = 0; k < NC; k++)
      if (k < seen.size()) chk({tag, "_sad_list"}, seen[k], exp_sad[k]);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_best_idx"}, 32'(best_idx), exp_bidx);
    chk({tag, "_best_sad"}, 32'(best_sad), exp_bsad);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  int exp_ramp  [NC] = '{0, 64, 128, 192, 256, 0, 384, 448, 512};
  int exp_ramp3 [NC] = '{192, 64, 128, 192, 256, 0, 384, 448, 512};
  int exp_tie   [NC] = '{64, 64, 64, 64, 64, 64, 64, 64, 64};
  int exp_max   [NC] = '{16320, 16320, 16320, 16320, 16320, 16320, 16320, 16320, 16320};

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    row_valid = 1'b0;
    pred_row  = '0;
    orig_row  = '0;
    last_row_time = 0;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("reset_busy",     32'(busy),     0);
    chk("reset_best_sad", 32'(best_sad), 0);
    chk("reset_cand_sad", 32'(cand_sad), 0);

    // Ramp: candidate 0 and 5 both score 0; the tie keeps index 0.
    run_search(0, 0, 1'b0, 1'b0);
    check_results("ramp", exp_ramp, 0, 0);
    chk("done_latency", done_time - last_row_time, 10);

    // Candidate 0 worse than 5: best moves to the strictly lower SAD.
    run_search(0, 3, 1'b0, 1'b0);
    check_results("ramp3", exp_ramp3, 5, 0);

    run_search(1, 0, 1'b0, 1'b0);
    check_results("tie", exp_tie, 0, 64);

    run_search(2, 0, 1'b0, 1'b0);
    check_results("max", exp_max, 0, 16320);

    // Gapped rows, plus rows offered while idle and on the start cycle.
    run_search(0, 0, 1'b1, 1'b1);
    check_results("gaps", exp_ramp, 0, 0);

    // Abort after 20 rows, 30 rows of a fresh search, then reset mid-search.
    done_cnt = 0;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    send_rows(0, 0, 1'b0, 20);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    seen.delete();
    send_rows(0, 0, 1'b0, 30);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("abort_num_cand", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("abort_sad0", seen[0], 0);
      chk("abort_sad1", seen[1], 64);
      chk("abort_sad2", seen[2], 128);
    end
    chk("abort_busy", 32'(busy), 1);
    drive(1'b1, 1'b1, 1'b1, {8{8'hFF}}, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("rst_busy",       32'(busy),       0);
    chk("rst_cand_valid", 32'(cand_valid), 0);
    chk("rst_cand_sad",   32'(cand_sad),   0);
    chk("rst_cand_idx",   32'(cand_idx),   0);
    chk("rst_done",       32'(done),       0);
    chk("rst_best_idx",   32'(best_idx),   0);
    chk("rst_best_sad",   32'(best_sad),   0);
    for (int n = 0; n < 3; n++) drive(1'b0, 1'b0, 1'b1, '0, {8{8'h10}});
    chk("abort_no_done", done_cnt, 0);
    chk("rst_stays_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
